// File: rtl/sn76489_pkg.sv
// Shared definitions for the SN76489 bus writer: register codes, FSM encoding
// and the frequency-register classifier.
package sn76489_pkg;

    localparam logic [2:0] FREQ1_REG      = 3'b000;
    localparam logic [2:0] FREQ2_REG      = 3'b010;
    localparam logic [2:0] FREQ3_REG      = 3'b001;
    localparam logic [2:0] ATT1_REG       = 3'b100;
    localparam logic [2:0] ATT2_REG       = 3'b110;
    localparam logic [2:0] ATT3_REG       = 3'b101;
    localparam logic [2:0] ATT_NOISE_REG  = 3'b111;
    localparam logic [2:0] NOISE_CTRL_REG = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } writer_state_t;

    // Tone-frequency registers carry 10 bits and therefore need a data byte.
    function automatic logic isFreqReg(input logic [2:0] reg_code);
        return (reg_code == FREQ1_REG) || (reg_code == FREQ2_REG) ||
               (reg_code == FREQ3_REG);
    endfunction

endpackage

// File: rtl/sn76489_write_encoder.sv
// Pure combinational encoder from a logical register write to the one or two
// PSG bytes that implement it.
module sn76489_write_encoder
    import sn76489_pkg::*;
(
    input  logic [2:0] regCode,
    input  logic [9:0] value,
    output logic [7:0] latchByte,
    output logic [7:0] dataByte,
    output logic       twoBytes
);

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        twoBytes  = isFreqReg(regCode);
        latchByte = {value[3:0], regCode, 1'b1};
        dataByte  = {value[5:0], 2'b00};
        if (twoBytes) begin
            latchByte = {value[9:6], regCode, 1'b1};
        end
    end

endmodule

// File: rtl/sn76489_bus_writer.sv
// Bus-master write front end for the SN76489 PSG (d/nCE/nWE cycle with ready).
// Optional STROBE timeout abort: define SN76489_WRITER_TIMEOUT_EN.
module sn76489_bus_writer
    import sn76489_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned RECOVERY_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [2:0] reqReg,
    input  logic [9:0] reqValue,
    output logic [7:0] d,
    output logic       nCE,
    output logic       nWE,
    input  logic       ready,
    output logic       done,
    output logic       error
);

    if (SETUP_CYCLES < 1 || RECOVERY_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("sn76489_bus_writer: cycle parameters out of range");
    end

    logic [7:0]    latch_byte;
    logic [7:0]    data_byte;
    logic          two_bytes;
    logic [7:0]    data_q;
    logic          second_pending;
    logic [15:0]   phase_cnt;
    writer_state_t state;

    sn76489_write_encoder u_encoder (
        .regCode  (reqReg),
        .value    (reqValue),
        .latchByte(latch_byte),
        .dataByte (data_byte),
        .twoBytes (two_bytes)
    );

`ifdef SN76489_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] strobe_cnt;
    logic          aborted;
    logic          error_q;
    assign error = error_q;
`else
    logic          strobe_first;
    assign error = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            d              <= 8'h00;
            nCE            <= 1'b1;
            nWE            <= 1'b1;
            reqReady       <= 1'b1;
            done           <= 1'b0;
            data_q         <= 8'h00;
            second_pending <= 1'b0;
            phase_cnt      <= '0;
`ifdef SN76489_WRITER_TIMEOUT_EN
            strobe_cnt     <= '0;
            aborted        <= 1'b0;
            error_q        <= 1'b0;
`else
            strobe_first   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SN76489_WRITER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        d              <= latch_byte;
                        data_q         <= data_byte;
                        second_pending <= two_bytes;
                        nCE            <= 1'b0;
                        reqReady       <= 1'b0;
                        phase_cnt      <= '0;
                        state          <= SETUP;
`ifdef SN76489_WRITER_TIMEOUT_EN
                        aborted        <= 1'b0;
`endif
                    end
                end

                SETUP: begin
                    if (phase_cnt == 16'(SETUP_CYCLES - 1)) begin
                        nWE       <= 1'b0;
                        phase_cnt <= '0;
                        state     <= STROBE;
`ifdef SN76489_WRITER_TIMEOUT_EN
                        strobe_cnt   <= '0;
`else
                        strobe_first <= 1'b1;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                // The first STROBE cycle ignores ready: the chip has not dropped it yet.
                STROBE: begin
`ifdef SN76489_WRITER_TIMEOUT_EN
                    if (strobe_cnt != '0 && ready) begin
                        nCE   <= 1'b1;
                        nWE   <= 1'b1;
                        state <= RECOVER;
                    end else if (strobe_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        nCE     <= 1'b1;
                        nWE     <= 1'b1;
                        aborted <= 1'b1;
                        state   <= RECOVER;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
`else
                    strobe_first <= 1'b0;
                    if (!strobe_first && ready) begin
                        nCE   <= 1'b1;
                        nWE   <= 1'b1;
                        state <= RECOVER;
                    end
`endif
                end

                RECOVER: begin
                    if (phase_cnt == 16'(RECOVERY_CYCLES - 1)) begin
                        phase_cnt <= '0;
`ifdef SN76489_WRITER_TIMEOUT_EN
                        if (second_pending && !aborted) begin
`else
                        if (second_pending) begin
`endif
                            d              <= data_q;
                            second_pending <= 1'b0;
                            nCE            <= 1'b0;
                            state          <= SETUP;
                        end else begin
                            second_pending <= 1'b0;
                            reqReady       <= 1'b1;
                            state          <= IDLE;
`ifdef SN76489_WRITER_TIMEOUT_EN
                            done           <= !aborted;
                            error_q        <= aborted;
`else
                            done           <= 1'b1;
`endif
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    nCE      <= 1'b1;
                    nWE      <= 1'b1;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Self-checking bench for sn76489_bus_writer: vector table, byte scoreboard
// fed by a bus monitor, and hand-written reset/back-to-back/stall sequences.
module tb_sn76489_bus_writer;
    import sn76489_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       reqValid;
    logic       reqReady;
    logic [2:0] reqReg;
    logic [9:0] reqValue;
    logic [7:0] d;
    logic       nCE;
    logic       nWE;
    logic       ready;
    logic       done;
    logic       error;

    sn76489_bus_writer dut (
        .clock   (clock),
        .reset   (reset),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqReg  (reqReg),
        .reqValue(reqValue),
        .d       (d),
        .nCE     (nCE),
        .nWE     (nWE),
        .ready   (ready),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;

    // PSG ready model: in normal mode ready stays low for the first `hold`
    // cycles of each nWE-low pulse.
    typedef enum {M_NORMAL, M_HIGH, M_LOW} ready_mode_t;
    ready_mode_t mode;
    int          hold;
    int          age;

    always @(posedge clock) age <= nWE ? 0 : age + 1;

    always_comb begin
        ready = 1'b1;
        case (mode)
            M_HIGH:  ready = 1'b1;
            M_LOW:   ready = 1'b0;
            default: ready = !(nWE == 1'b0 && age < hold);
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected bus bytes in order; the monitor pops one per nCE-low burst.
    logic [7:0] exp_q[$];
    logic [7:0] cur_exp = 8'h00;
    logic       prev_nce = 1'b1;
    logic       prev_nwe = 1'b1;
    int         strobe_pulses = 0;
    int         strobe_cycles = 0;
    int         dones = 0;
    int         errors = 0;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (nCE === 1'b0 && prev_nce === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", d);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("bus_byte", 32'(d), 32'(cur_exp));
                end
            end else if (nCE === 1'b0) begin
                check("d_stable", 32'(d), 32'(cur_exp));
            end
            if (nWE === 1'b0 && prev_nwe === 1'b1) strobe_pulses++;
            if (nWE === 1'b0) strobe_cycles++;
            if (done === 1'b1) dones++;
            if (error === 1'b1) errors++;
        end
        prev_nce = nCE;
        prev_nwe = nWE;
    end

    // Called at posedge+1; presents the request and returns at posedge+1 after the accept edge.
    task automatic send(input logic [2:0] r, input logic [9:0] v);
        for (int i = 0; i < 200 && reqReady !== 1'b1; i++) begin
            @(posedge clock);
            #1;
        end
        check("req_ready_before_send", 32'(reqReady), 32'd1);
        reqReg   = r;
        reqValue = v;
        reqValid = 1'b1;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        reqReg   = ~r;
        reqValue = ~v;
    endtask

    task automatic wait_flag(input bit want_error, output int edges);
        bit seen = 1'b0;
        edges = -1;
        for (int i = 1; i <= 2000 && !seen; i++) begin
            @(posedge clock);
            #1;
            if ((want_error ? error : done) === 1'b1) begin
                edges = i;
                seen  = 1'b1;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_%s actual=timeout required=pulse", want_error ? "error" : "done");
        end
    endtask

    typedef struct {
        logic [2:0] r;
        logic [9:0] v;
        logic [7:0] lb;
        logic [7:0] db;
        bit         two;
        int         hold;
        string      name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, p0, d0, s0;

        vecs[0] = '{FREQ1_REG,      10'd330,   8'h51, 8'h28, 1'b1, 1, "freq1_330"};
        vecs[1] = '{ATT2_REG,       10'h005,   8'h5D, 8'h00, 1'b0, 1, "att2_5"};
        vecs[2] = '{NOISE_CTRL_REG, 10'h006,   8'h67, 8'h00, 1'b0, 1, "noise_0110"};
        vecs[3] = '{FREQ3_REG,      10'h3FF,   8'hF3, 8'hFC, 1'b1, 3, "freq3_3ff"};
        vecs[4] = '{ATT1_REG,       10'h2A7,   8'h79, 8'h00, 1'b0, 2, "att1_hi_ignored"};
        vecs[5] = '{ATT_NOISE_REG,  10'h00F,   8'hFF, 8'h00, 1'b0, 1, "attnoise_f"};
        vecs[6] = '{FREQ2_REG,      10'h000,   8'h05, 8'h00, 1'b1, 1, "freq2_0"};

        reset    = 1'b0;
        reqValid = 1'b0;
        reqReg   = 3'b000;
        reqValue = 10'h000;
        mode     = M_NORMAL;
        hold     = 1;

        #2 reset = 1'b1;
        #1;
        check("rst_d",        32'(d),        32'h00);
        check("rst_nce",      32'(nCE),      32'd1);
        check("rst_nwe",      32'(nWE),      32'd1);
        check("rst_reqready", 32'(reqReady), 32'd1);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;

        // Vector table: per byte 1 setup + (hold+1) strobe + 1 recovery cycles.
        foreach (vecs[i]) begin
            hold = vecs[i].hold;
            exp_q.push_back(vecs[i].lb);
            if (vecs[i].two) exp_q.push_back(vecs[i].db);
            p0 = strobe_pulses;
            d0 = dones;
            send(vecs[i].r, vecs[i].v);
            wait_flag(1'b0, e);
            check({vecs[i].name, "_latency"}, 32'(e), 32'((vecs[i].two ? 2 : 1) * (vecs[i].hold + 3)));
            check({vecs[i].name, "_reqready_on_done"}, 32'(reqReady), 32'd1);
            @(posedge clock);
            #1;
            check({vecs[i].name, "_done_one_cycle"}, 32'(done), 32'd0);
            check({vecs[i].name, "_strobes"}, 32'(strobe_pulses - p0), 32'(vecs[i].two ? 2 : 1));
            check({vecs[i].name, "_done_count"}, 32'(dones - d0), 32'd1);
            check({vecs[i].name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        end

        // Asynchronous reset in the middle of a STROBE of the freq2 latch byte.
        hold = 5;
        exp_q.push_back(8'h05);
        send(FREQ2_REG, 10'h000);
        for (int i = 0; i < 50 && nWE !== 1'b0; i++) begin
            @(posedge clock);
            #1;
        end
        check("midrst_in_strobe", 32'(nWE), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("midrst_nce", 32'(nCE), 32'd1);
        check("midrst_nwe", 32'(nWE), 32'd1);
        check("midrst_d",   32'(d),   32'h00);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        exp_q.delete();
        d0 = dones;
        repeat (20) @(posedge clock);
        #1;
        check("midrst_no_done",  32'(dones - d0), 32'd0);
        check("midrst_reqready", 32'(reqReady),   32'd1);
        check("midrst_idle_nce", 32'(nCE),        32'd1);

        // ready never drops; then a back-to-back request accepted on the done cycle.
        mode = M_HIGH;
        exp_q.push_back(8'h39);
        exp_q.push_back(8'hDB);
        p0 = strobe_pulses;
        send(ATT1_REG, 10'h003);
        reqReg   = ATT3_REG;
        reqValue = 10'h00D;
        reqValid = 1'b1;
        wait_flag(1'b0, e);
        check("ready_high_latency", 32'(e), 32'd4);
        check("b2b_reqready_on_done", 32'(reqReady), 32'd1);
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        reqReg   = 3'b000;
        reqValue = 10'h3F0;
        check("b2b_accepted_on_done", 32'(reqReady), 32'd0);
        check("b2b_nce_low", 32'(nCE), 32'd0);
        wait_flag(1'b0, e);
        check("b2b_latency", 32'(e), 32'd4);
        check("b2b_strobes", 32'(strobe_pulses - p0), 32'd2);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;

        // ready stuck low.
        mode = M_LOW;
        p0 = strobe_pulses;
        d0 = dones;
        s0 = strobe_cycles;
`ifdef SN76489_WRITER_TIMEOUT_EN
        exp_q.push_back(8'h55);
        send(FREQ2_REG, 10'h155);
        wait_flag(1'b1, e);
        check("timeout_latency", 32'(e), 32'd66);
        check("timeout_nce", 32'(nCE), 32'd1);
        check("timeout_nwe", 32'(nWE), 32'd1);
        @(posedge clock);
        #1;
        check("timeout_error_one_cycle", 32'(error), 32'd0);
        check("timeout_strobe_cycles", 32'(strobe_cycles - s0), 32'd64);
        repeat (10) @(posedge clock);
        #1;
        check("timeout_second_skipped", 32'(strobe_pulses - p0), 32'd1);
        check("timeout_no_done", 32'(dones - d0), 32'd0);
        check("timeout_reqready", 32'(reqReady), 32'd1);
        check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
        mode = M_NORMAL;
`else
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h54);
        send(FREQ2_REG, 10'h155);
        repeat (1000) @(posedge clock);
        #1;
        check("stuck_still_strobe_nwe", 32'(nWE), 32'd0);
        check("stuck_still_strobe_nce", 32'(nCE), 32'd0);
        check("stuck_error_low", 32'(error), 32'd0);
        check("stuck_no_error_pulse", 32'(errors), 32'd0);
        check("stuck_no_done", 32'(dones - d0), 32'd0);
        mode = M_NORMAL;
        hold = 0;
        wait_flag(1'b0, e);
        check("stuck_release_strobes", 32'(strobe_pulses - p0), 32'd2);
        check("stuck_release_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
